// File: rtl/imem_boot_loader.sv
// rtl/imem_boot_loader.sv - framed byte-stream loader for the core instruction memory
//
// Receives LEN0 LEN1 (word count N, little-endian), then N little-endian
// 32-bit words, then an XOR checksum byte. Writes each word to consecutive
// instruction-memory word addresses starting at 0, and releases the core
// from reset only once the checksum matches.
//
// Ports:
//   clk        in   system clock, rising edge
//   reset      in   synchronous active-low reset
//   rx_data    in   [7:0] image byte
//   rx_valid   in   rx_data valid
//   rx_ready   out  byte accepted on an edge where rx_valid && rx_ready
//   im_we      out  instruction-memory write enable, one-cycle pulse
//   im_addr    out  [ADDR_W-1:0] instruction-memory word address
//   im_wdata   out  [31:0] instruction word
//   core_reset out  active-high core reset, released only in the done state
//   done       out  image loaded with good checksum (sticky until reset)
//   error      out  length overflow or checksum mismatch (sticky until reset)

module imem_boot_loader #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic              im_we,
    output logic [ADDR_W-1:0] im_addr,
    output logic [31:0]       im_wdata,
    output logic              core_reset,
    output logic              done,
    output logic              error
);

    typedef enum logic [2:0] {
        S_LEN0,
        S_LEN1,
        S_DATA,
        S_WRITE,
        S_CSUM,
        S_DONE,
        S_ERR
    } state_t;

    // Capacity in words; N equal to this is legal, anything above overflows.
    localparam logic [16:0] MAX_WORDS = 17'd1 << ADDR_W;

    state_t            state;
    state_t            state_next;
    logic [7:0]        len_lo;
    logic [15:0]       len;
    logic [1:0]        byte_cnt;
    logic [ADDR_W-1:0] word_idx;
    logic [7:0]        acc;
    logic [23:0]       word_sr;

    logic              xfer;
    logic [15:0]       len_rx;
    logic [16:0]       idx_plus1;
    logic              ready_next;

    assign xfer   = rx_valid && rx_ready;
    assign len_rx = {rx_data, len_lo};
    // Widened so that the last word of a full-capacity image compares equal
    // to N even though word_idx itself wraps to 0.
    assign idx_plus1 = {{(17 - ADDR_W){1'b0}}, word_idx} + 17'd1;

    always_comb begin
        state_next = state;
        case (state)
            S_LEN0: begin
                if (xfer) state_next = S_LEN1;
            end
            S_LEN1: begin
                if (xfer) begin
                    if ({1'b0, len_rx} > MAX_WORDS) state_next = S_ERR;
                    else if (len_rx == 16'd0)       state_next = S_CSUM;
                    else                            state_next = S_DATA;
                end
            end
            S_DATA: begin
                if (xfer && byte_cnt == 2'd3) state_next = S_WRITE;
            end
            S_WRITE: begin
                if (idx_plus1 == {1'b0, len}) state_next = S_CSUM;
                else                          state_next = S_DATA;
            end
            S_CSUM: begin
                if (xfer) state_next = (rx_data == acc) ? S_DONE : S_ERR;
            end
            default: state_next = state;
        endcase
    end

    // Outputs are registered from the next state so they change on the same
    // edge as the state transition (rx_ready drops as S_WRITE is entered).
    assign ready_next = (state_next == S_LEN0) || (state_next == S_LEN1) ||
                        (state_next == S_DATA) || (state_next == S_CSUM);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= S_LEN0;
            rx_ready   <= 1'b0;
            im_we      <= 1'b0;
            im_addr    <= '0;
            im_wdata   <= '0;
            core_reset <= 1'b1;
            done       <= 1'b0;
            error      <= 1'b0;
            len_lo     <= '0;
            len        <= '0;
            byte_cnt   <= '0;
            word_idx   <= '0;
            acc        <= '0;
            word_sr    <= '0;
        end else begin
            state      <= state_next;
            rx_ready   <= ready_next;
            im_we      <= (state_next == S_WRITE);
            core_reset <= (state_next != S_DONE);
            done       <= (state_next == S_DONE);
            error      <= (state_next == S_ERR);

            // The checksum byte itself is not folded into the accumulator.
            if (xfer && state != S_CSUM) acc <= acc ^ rx_data;

            case (state)
                S_LEN0: if (xfer) len_lo <= rx_data;
                S_LEN1: if (xfer) len <= len_rx;
                S_DATA: begin
                    if (xfer) begin
                        byte_cnt <= byte_cnt + 2'd1;
                        case (byte_cnt)
                            2'd0: word_sr[7:0]   <= rx_data;
                            2'd1: word_sr[15:8]  <= rx_data;
                            2'd2: word_sr[23:16] <= rx_data;
                            default: begin
                                im_wdata <= {rx_data, word_sr};
                                im_addr  <= word_idx;
                            end
                        endcase
                    end
                end
                S_WRITE: word_idx <= word_idx + 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_boot_loader.sv
// tb/tb_imem_boot_loader.sv - directed self-checking bench for imem_boot_loader

module tb_imem_boot_loader;

    logic        clk;
    logic        reset;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        im_we;
    logic [7:0]  im_addr;
    logic [31:0] im_wdata;
    logic        core_reset;
    logic        done;
    logic        error;

    int checks;
    int failures;
    int cyc;
    int acc_cyc;
    int first_we_cyc;
    int b6_cyc;

    logic [7:0]  wr_addr [$];
    logic [31:0] wr_data [$];
    logic [7:0]  stream [0:15];

    imem_boot_loader #(.ADDR_W(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .im_we      (im_we),
        .im_addr    (im_addr),
        .im_wdata   (im_wdata),
        .core_reset (core_reset),
        .done       (done),
        .error      (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Write monitor: log every pulse and confirm no byte is accepted during it.
    always @(negedge clk) begin
        if (im_we === 1'b1) begin
            checks++;
            if (rx_ready !== 1'b0) begin
                failures++;
                $display("FAIL ready_in_write: rx_ready=%b required 0", rx_ready);
            end
            if (wr_addr.size() == 0) first_we_cyc = cyc;
            wr_addr.push_back(im_addr);
            wr_data.push_back(im_wdata);
        end
    end

    task automatic send_byte(input logic [7:0] b);
        bit ok;
        ok       = 1'b0;
        rx_data  = b;
        rx_valid = 1'b1;
        for (int t = 0; t < 100 && !ok; t++) begin
            @(negedge clk);
            if (rx_ready === 1'b1) begin
                acc_cyc = cyc;
                ok = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        if (!ok) begin
            checks++;
            failures++;
            $display("FAIL send_timeout: byte %h not accepted in 100 cycles", b);
        end
    endtask

    task automatic send_stream(input int n, input int gap, input int nogap_idx);
        for (int i = 0; i < n; i++) begin
            if (gap > 0 && i > 0 && i != nogap_idx) begin
                rx_valid = 1'b0;
                repeat (gap) @(posedge clk);
                #1;
            end
            send_byte(stream[i]);
            if (i == 6) b6_cyc = acc_cyc;
        end
        rx_valid = 1'b0;
    endtask

    task automatic load_good();
        stream[0] = 8'h02; stream[1] = 8'h00; stream[2] = 8'h93; stream[3] = 8'h00;
        stream[4] = 8'h50; stream[5] = 8'h00; stream[6] = 8'h13; stream[7] = 8'h01;
        stream[8] = 8'h10; stream[9] = 8'h00; stream[10] = 8'hC3;
    endtask

    task automatic do_reset();
        reset    = 1'b0;
        rx_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        wr_addr.delete();
        wr_data.delete();
    endtask

    task automatic test_reset();
        reset    = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({rx_ready, im_we, core_reset, done, error} !== 5'b00100) begin
            failures++;
            $display("FAIL reset_flags: rdy/we/crst/done/err=%b required 00100",
                     {rx_ready, im_we, core_reset, done, error});
        end
        checks++;
        if (im_addr !== 8'h00 || im_wdata !== 32'h0) begin
            failures++;
            $display("FAIL reset_mem: addr=%h data=%h required 00 00000000", im_addr, im_wdata);
        end
        reset = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (rx_ready !== 1'b1 || core_reset !== 1'b1) begin
            failures++;
            $display("FAIL reset_release: rx_ready=%b core_reset=%b required 1 1", rx_ready, core_reset);
        end
    endtask

    task automatic test_normal();
        do_reset();
        load_good();
        send_stream(11, 0, -1);
        checks++;
        if (wr_addr.size() != 2) begin
            failures++;
            $display("FAIL normal_nwrites: %0d required 2", wr_addr.size());
        end else begin
            checks++;
            if (wr_addr[0] !== 8'd0 || wr_data[0] !== 32'h00500093) begin
                failures++;
                $display("FAIL normal_w0: addr=%h data=%h required 00 00500093", wr_addr[0], wr_data[0]);
            end
            checks++;
            if (wr_addr[1] !== 8'd1 || wr_data[1] !== 32'h00100113) begin
                failures++;
                $display("FAIL normal_w1: addr=%h data=%h required 01 00100113", wr_addr[1], wr_data[1]);
            end
        end
        checks++;
        if ({done, error, core_reset, rx_ready} !== 4'b1000) begin
            failures++;
            $display("FAIL normal_final: done/err/crst/rdy=%b required 1000",
                     {done, error, core_reset, rx_ready});
        end
        checks++;
        if (im_addr !== 8'd1 || im_wdata !== 32'h00100113) begin
            failures++;
            $display("FAIL normal_hold: addr=%h data=%h required 01 00100113", im_addr, im_wdata);
        end
    endtask

    task automatic test_bad_checksum();
        do_reset();
        load_good();
        stream[10] = 8'hC2;
        send_stream(11, 0, -1);
        checks++;
        if (wr_addr.size() != 2) begin
            failures++;
            $display("FAIL badcs_nwrites: %0d required 2", wr_addr.size());
        end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({done, error, core_reset, rx_ready} !== 4'b0110) begin
            failures++;
            $display("FAIL badcs_final: done/err/crst/rdy=%b required 0110",
                     {done, error, core_reset, rx_ready});
        end
    endtask

    task automatic test_empty();
        do_reset();
        stream[0] = 8'h00; stream[1] = 8'h00; stream[2] = 8'h00;
        send_stream(3, 0, -1);
        checks++;
        if ({done, error, core_reset} !== 3'b100) begin
            failures++;
            $display("FAIL empty_final: done/err/crst=%b required 100", {done, error, core_reset});
        end
        checks++;
        if (wr_addr.size() != 0) begin
            failures++;
            $display("FAIL empty_nwrites: %0d required 0", wr_addr.size());
        end
    endtask

    task automatic test_overflow();
        do_reset();
        stream[0] = 8'h01; stream[1] = 8'h01;
        send_stream(2, 0, -1);
        checks++;
        if ({done, error, core_reset, rx_ready} !== 4'b0110) begin
            failures++;
            $display("FAIL ovf_final: done/err/crst/rdy=%b required 0110",
                     {done, error, core_reset, rx_ready});
        end
        rx_data  = 8'hAA;
        rx_valid = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        rx_valid = 1'b0;
        checks++;
        if (wr_addr.size() != 0 || rx_ready !== 1'b0 || error !== 1'b1) begin
            failures++;
            $display("FAIL ovf_ignore: writes=%0d rx_ready=%b error=%b required 0 0 1",
                     wr_addr.size(), rx_ready, error);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        load_good();
        // Gaps between every byte except where byte 6 arrives during the first write.
        send_stream(11, 3, 6);
        checks++;
        if (wr_addr.size() != 2) begin
            failures++;
            $display("FAIL gaps_nwrites: %0d required 2", wr_addr.size());
        end else begin
            checks++;
            if (wr_data[0] !== 32'h00500093 || wr_data[1] !== 32'h00100113 || wr_addr[1] !== 8'd1) begin
                failures++;
                $display("FAIL gaps_words: %h %h addr1=%h required 00500093 00100113 01",
                         wr_data[0], wr_data[1], wr_addr[1]);
            end
        end
        checks++;
        if (b6_cyc != first_we_cyc + 1) begin
            failures++;
            $display("FAIL gaps_stall: byte accepted in cycle %0d required %0d", b6_cyc, first_we_cyc + 1);
        end
        checks++;
        if ({done, error, core_reset} !== 3'b100) begin
            failures++;
            $display("FAIL gaps_final: done/err/crst=%b required 100", {done, error, core_reset});
        end
    endtask

    task automatic test_reset_mid_load();
        do_reset();
        load_good();
        send_stream(5, 0, -1);
        reset = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if ({rx_ready, im_we, core_reset, done, error} !== 5'b00100 || im_addr !== 8'h00) begin
            failures++;
            $display("FAIL midrst_state: rdy/we/crst/done/err=%b addr=%h required 00100 00",
                     {rx_ready, im_we, core_reset, done, error}, im_addr);
        end
        reset = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (rx_ready !== 1'b1) begin
            failures++;
            $display("FAIL midrst_ready: rx_ready=%b required 1", rx_ready);
        end
        send_stream(11, 0, -1);
        checks++;
        if (wr_addr.size() != 2) begin
            failures++;
            $display("FAIL midrst_nwrites: %0d required 2", wr_addr.size());
        end else begin
            checks++;
            if (wr_addr[0] !== 8'd0 || wr_data[0] !== 32'h00500093 ||
                wr_addr[1] !== 8'd1 || wr_data[1] !== 32'h00100113) begin
                failures++;
                $display("FAIL midrst_words: %h:%h %h:%h required 00:00500093 01:00100113",
                         wr_addr[0], wr_data[0], wr_addr[1], wr_data[1]);
            end
        end
        checks++;
        if ({done, error, core_reset} !== 3'b100) begin
            failures++;
            $display("FAIL midrst_final: done/err/crst=%b required 100", {done, error, core_reset});
        end
    endtask

    initial begin
        checks       = 0;
        failures     = 0;
        cyc          = 0;
        acc_cyc      = 0;
        first_we_cyc = 0;
        b6_cyc       = 0;
        reset        = 1'b0;
        rx_valid     = 1'b0;
        rx_data      = 8'h00;
        test_reset();
        test_normal();
        test_bad_checksum();
        test_empty();
        test_overflow();
        test_back_to_back();
        test_reset_mid_load();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
